// File: rtl/alu_checker.sv
// alu_checker: sweeps all 1024 {op,inA,inB} vectors through a 4-bit ALU and scores its answers
// Ports: clk/reset (sync, active-high); start begins a sweep from IDLE; ans_in is the ALU result.
//        inA/inB/op drive the ALU; busy marks a sweep; done pulses once at the end;
//        pass/err_cnt report the last sweep; fail_vec/fail_ans hold the first failure.
// Config: define ALU_CHECKER_FAILLOG_EN to build the first-failure capture; otherwise
//         fail_vec/fail_ans are tied to zero.
module alu_checker #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] ans_in,
  output logic [3:0] inA,
  output logic [3:0] inB,
  output logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [9:0] fail_vec,
  output logic [3:0] fail_ans
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [3:0] LAST  = 4'(SETTLE - 1);
  logic [1:0] r_state;
  logic [9:0] r_idx;
  logic [3:0] r_cnt;
  logic [7:0] r_err;
  logic       r_pass;
  logic [3:0] w_exp;
  logic       w_cmp;
  logic       w_miss;
  logic       w_accept;
  logic [7:0] w_err_nxt;
  assign {op, inA, inB} = r_idx;
  assign busy    = r_state == DRIVE;
  assign done    = r_state == DONE;
  assign pass    = r_pass;
  assign err_cnt = r_err;
  always_comb begin
    w_exp     = op == 2'd0 ? inA + inB :
                op == 2'd1 ? inA - inB :
                op == 2'd2 ? inA & inB : inA | inB;
    w_accept  = r_state == IDLE && start;
    w_cmp     = r_state == DRIVE && r_cnt == LAST;
    w_miss    = w_cmp && ans_in != w_exp;
    w_err_nxt = (w_miss && r_err != 8'hFF) ? r_err + 8'd1 : r_err;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_pass  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_state <= DRIVE;
        r_idx   <= '0;
        r_cnt   <= '0;
        r_err   <= '0;
        r_pass  <= 1'b0;
      end
    end else if (r_state == DRIVE) begin
      r_err <= w_err_nxt;
      if (w_cmp) begin
        r_cnt <= '0;
        if (r_idx == 10'h3FF) begin
          r_state <= DONE;
          r_pass  <= w_err_nxt == 8'd0;
        end else begin
          r_idx <= r_idx + 10'd1;
        end
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end else begin
      r_state <= IDLE;
    end
  end
`ifdef ALU_CHECKER_FAILLOG_EN
  logic [9:0] r_fail_vec;
  logic [3:0] r_fail_ans;
  assign fail_vec = r_fail_vec;
  assign fail_ans = r_fail_ans;
  // A zero running count means this mismatch is the first of the sweep.
  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_fail_vec <= '0;
      r_fail_ans <= '0;
    end else if (w_miss && r_err == 8'd0) begin
      r_fail_vec <= r_idx;
      r_fail_ans <= ans_in;
    end
  end
`else
  assign fail_vec = '0;
  assign fail_ans = '0;
`endif
endmodule

// File: tb/tb_alu_checker.sv
// tb_alu_checker: directed tests for alu_checker with SETTLE=1 and SETTLE=3 instances
module tb_alu_checker;
  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start3;
  logic [3:0] ans1, ans3;
  logic [3:0] a1, b1, a3, b3;
  logic [1:0] op1, op3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [7:0] err1, err3;
  logic [9:0] fv1, fv3;
  logic [3:0] fa1, fa3;
  int         mode;
  int         n_checks = 0;
  int         n_fail = 0;
`ifdef ALU_CHECKER_FAILLOG_EN
  localparam logic [9:0] FAULT_VEC = 10'h32E;
  localparam logic [3:0] STUCK_ANS = 4'hF;
`else
  localparam logic [9:0] FAULT_VEC = 10'h000;
  localparam logic [3:0] STUCK_ANS = 4'h0;
`endif
  always #5 clk = ~clk;
  alu_checker #(.SETTLE(1)) dut (
    .clk(clk), .reset(reset), .start(start1), .ans_in(ans1),
    .inA(a1), .inB(b1), .op(op1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fv1), .fail_ans(fa1)
  );
  alu_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .ans_in(ans3),
    .inA(a3), .inB(b3), .op(op3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_vec(fv3), .fail_ans(fa3)
  );
  function automatic logic [3:0] alu_ref(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    case (o)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction
  // mode 0: good ALU, 1: single wrong answer at 0x32E, 2: output stuck at F
  always_comb ans1 = mode == 2 ? 4'hF : (mode == 1 && {op1, a1, b1} == 10'h32E) ? 4'h0 : alu_ref(op1, a1, b1);
  always_comb ans3 = alu_ref(op3, a3, b3);
  task automatic sweep1(input bit poke, output int cyc);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 5000) begin
      start1 = poke && cyc == 10;
      @(negedge clk);
      cyc++;
    end
    start1 = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    mode = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({op1, a1, b1, busy1, done1, pass1, err1, fv1, fa1} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_s1: got %0h expected 0", {op1, a1, b1, busy1, done1, pass1, err1, fv1, fa1});
    end
    n_checks++;
    if ({op3, a3, b3, busy3, done3, pass3, err3, fv3, fa3} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_s3: got %0h expected 0", {op3, a3, b3, busy3, done3, pass3, err3, fv3, fa3});
    end
    reset = 1'b0;
  endtask
  task automatic test_pass_sweep;
    int cyc;
    mode = 0;
    sweep1(1'b0, cyc);
    n_checks++;
    if (cyc !== 1024) begin
      n_fail++;
      $display("FAIL pass_latency: got %0d expected 1024", cyc);
    end
    n_checks++;
    if ({done1, busy1, pass1, err1} !== {1'b1, 1'b0, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL pass_status: got done=%b busy=%b pass=%b err=%0d expected 1 0 1 0", done1, busy1, pass1, err1);
    end
    @(negedge clk);
    n_checks++;
    if ({done1, busy1, pass1, op1, a1, b1} !== {1'b0, 1'b0, 1'b1, 10'h3FF}) begin
      n_fail++;
      $display("FAIL pass_after: got done=%b busy=%b pass=%b vec=%0h expected 0 0 1 3ff", done1, busy1, pass1, {op1, a1, b1});
    end
  endtask
  task automatic test_single_fault;
    int cyc;
    mode = 1;
    sweep1(1'b0, cyc);
    n_checks++;
    if ({cyc, err1, pass1} !== {32'd1024, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL fault_count: got cyc=%0d err=%0d pass=%b expected 1024 1 0", cyc, err1, pass1);
    end
    n_checks++;
    if ({fv1, fa1} !== {FAULT_VEC, 4'h0}) begin
      n_fail++;
      $display("FAIL fault_log: got vec=%0h ans=%0h expected %0h 0", fv1, fa1, FAULT_VEC);
    end
    mode = 0;
  endtask
  task automatic test_stuck;
    int cyc;
    mode = 2;
    sweep1(1'b0, cyc);
    n_checks++;
    if ({cyc, err1, pass1} !== {32'd1024, 8'd255, 1'b0}) begin
      n_fail++;
      $display("FAIL stuck_count: got cyc=%0d err=%0d pass=%b expected 1024 255 0", cyc, err1, pass1);
    end
    n_checks++;
    if ({fv1, fa1} !== {10'h000, STUCK_ANS}) begin
      n_fail++;
      $display("FAIL stuck_log: got vec=%0h ans=%0h expected 0 %0h", fv1, fa1, STUCK_ANS);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({err1, pass1} !== {8'd255, 1'b0}) begin
      n_fail++;
      $display("FAIL stuck_hold: got err=%0d pass=%b expected 255 0", err1, pass1);
    end
    mode = 0;
  endtask
  task automatic test_reset_abort;
    int cyc;
    int dones;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (500) @(negedge clk);
    n_checks++;
    if ({busy1, op1, a1, b1} !== {1'b1, 10'd500}) begin
      n_fail++;
      $display("FAIL abort_index: got busy=%b vec=%0d expected 1 500", busy1, {op1, a1, b1});
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({op1, a1, b1, busy1, done1, pass1, err1, fv1, fa1} !== 37'd0) begin
      n_fail++;
      $display("FAIL abort_reset: got %0h expected 0", {op1, a1, b1, busy1, done1, pass1, err1, fv1, fa1});
    end
    dones = 0;
    repeat (1100) begin
      @(negedge clk);
      if (done1 || busy1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", dones);
    end
    sweep1(1'b0, cyc);
    n_checks++;
    if ({cyc, pass1, err1, fv1, fa1} !== {32'd1024, 1'b1, 8'd0, 10'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL abort_rerun: got cyc=%0d pass=%b err=%0d vec=%0h ans=%0h expected 1024 1 0 0 0", cyc, pass1, err1, fv1, fa1);
    end
  endtask
  task automatic test_start_ignored;
    int cyc;
    int dones;
    sweep1(1'b1, cyc);
    n_checks++;
    if ({cyc, pass1, err1} !== {32'd1024, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL ignore_busy: got cyc=%0d pass=%b err=%0d expected 1024 1 0", cyc, pass1, err1);
    end
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    dones = 0;
    repeat (1100) begin
      if (done1 || busy1) dones++;
      @(negedge clk);
    end
    n_checks++;
    if ({dones, pass1, err1, op1, a1, b1} !== {32'd0, 1'b1, 8'd0, 10'h3FF}) begin
      n_fail++;
      $display("FAIL ignore_done: got active=%0d pass=%b err=%0d vec=%0h expected 0 1 0 3ff", dones, pass1, err1, {op1, a1, b1});
    end
  endtask
  task automatic test_settle3;
    int cyc;
    int bad;
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 0;
    bad = 0;
    while (!done3 && cyc < 10000) begin
      if (cyc < 12 && {op3, a3, b3} != 10'(cyc / 3)) bad++;
      if (!busy3) bad++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL settle3_hold: got %0d bad cycles expected 0", bad);
    end
    n_checks++;
    if ({cyc, pass3, err3, busy3} !== {32'd3072, 1'b1, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL settle3_done: got cyc=%0d pass=%b err=%0d busy=%b expected 3072 1 0 0", cyc, pass3, err3, busy3);
    end
    @(negedge clk);
    n_checks++;
    if ({done3, op3, a3, b3} !== {1'b0, 10'h3FF}) begin
      n_fail++;
      $display("FAIL settle3_after: got done=%b vec=%0h expected 0 3ff", done3, {op3, a3, b3});
    end
  endtask
  initial begin
    test_reset;
    test_pass_sweep;
    test_single_fault;
    test_stuck;
    test_reset_abort;
    test_start_ignored;
    test_settle3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning cycles each vector is held before ans_in is compared (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to run a full sweep, sampled only in IDLE.
REQ-005 SHALL have port ans_in  input  4  result returned by the 4-bit ALU under test.
REQ-006 SHALL have port inA  output  4  registered operand A driven to the ALU.
REQ-007 SHALL have port inB  output  4  registered operand B driven to the ALU.
REQ-008 SHALL have port op  output  2  registered ALU opcode.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of sweep.
REQ-011 SHALL have port pass  output  1  high when the last completed sweep had zero mismatches.
REQ-012 SHALL have port err_cnt  output  8  mismatch count for the current/last sweep, saturating.
REQ-013 SHALL have ports fail_vec (output, 10, first failing {op,inA,inB}) and fail_ans (output, 4, ans_in seen at that failure).

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, DONE; IDLE->DRIVE on start, DRIVE->DONE after compare of vector 1023, DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL sweep vector index 0..1023 in increasing order, index = {op, inA, inB}, inB in LSBs.
REQ-016 SHALL, on the edge accepting start, load index 0 onto op/inA/inB, clear err_cnt, pass, fail_vec, fail_ans, and enter DRIVE.
REQ-017 SHALL hold each vector for exactly SETTLE cycles; on the last edge of that window compare ans_in to expected, then advance index.
REQ-018 SHALL compute expected modulo 16: op 00 inA+inB; 01 inA-inB; 10 inA&inB; 11 inA|inB.
REQ-019 SHALL increment err_cnt on each mismatch, saturating at 255 (no wrap).
REQ-020 SHALL assert busy in every DRIVE cycle and nowhere else.
REQ-021 SHALL assert done only in the DONE cycle, exactly 1024*SETTLE cycles after the start-accepting edge.
REQ-022 SHALL set pass on entering DONE iff err_cnt==0, and hold pass and err_cnt until the next accepted start or reset.
REQ-023 SHALL ignore start while busy or in DONE; no restart, no counter change.
REQ-024 SHALL hold op/inA/inB at the last driven vector (0x3FF) after the sweep until next start.

Reset
REQ-025 SHALL, when reset is high at a clock edge, enter IDLE and drive inA=0, inB=0, op=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, fail_ans=0.
REQ-026 SHALL give reset priority over start and over any in-progress sweep; an aborted sweep produces no done pulse.

Configuration
REQ-027 SHALL use macro ALU_CHECKER_FAILLOG_EN to compile in first-failure logging.
REQ-028 SHALL, with ALU_CHECKER_FAILLOG_EN defined, capture fail_vec and fail_ans on the first mismatch of a sweep only and hold them until next start or reset.
REQ-029 SHALL, without ALU_CHECKER_FAILLOG_EN, tie fail_vec and fail_ans to 0 with no capture registers; all other behaviour identical.

Verification
REQ-030 SHALL cover: correct ALU model on ans_in, SETTLE=1, start pulse -> done 1024 cycles later, pass=1, err_cnt=0, busy low after.
REQ-031 SHALL cover: model correct except op=11,inA=0010,inB=1110 returns 0000 -> err_cnt=1, pass=0, fail_vec=0x32E, fail_ans=0 (FAILLOG_EN defined).
REQ-032 SHALL cover: ans_in stuck at 4'hF -> 910 mismatches, err_cnt saturates at 255, pass=0.
REQ-033 SHALL cover: reset asserted at vector index 500 -> next cycle all outputs at reset values, no done; fresh start then completes with pass=1.
REQ-034 SHALL cover: start re-pulsed at index 10 and in DONE cycle -> ignored, sweep and err_cnt unaffected, single done pulse.
REQ-035 SHALL cover: SETTLE=3, correct model -> each vector held 3 cycles, done 3072 cycles after start, pass=1.
